// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch initiator for the CPU front end.
//
// Owns the program counter, presents it to instruction memory, and captures
// each returned word into a small FIFO. Decode drains the FIFO through a
// valid/ready handshake. A redirect from execute loads a new PC and flushes
// everything still buffered.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target is kept as-is and produces a
//               single fault entry, after which fetch halts until the next
//               redirect.
//   undefined : redirect targets are forced word-aligned; out_fault is 0.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-low reset
//   imem_address    fetch address (the PC register itself)
//   imem_data       instruction word for imem_address (combinational memory)
//   imem_valid      imem_data is usable this cycle
//   redirect_valid  load redirect_pc and flush the FIFO
//   redirect_pc     redirect target
//   out_valid       FIFO head is valid
//   out_ready       decode accepts the head
//   out_instr       head instruction, NOP when empty
//   out_pc          PC of the head instruction, 0 when empty
//   out_fault       head is a misaligned-fetch fault entry
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int                PW      = $clog2(DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_FETCH, S_FAULT, S_HALT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;

  // Small FIFO storage; the head is read combinationally so a word pushed at
  // one edge is visible right after it.
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];

  logic          w_pop;
  logic          w_space;
  logic          w_push;
  logic          w_pc_advance;
  logic [31:0]   w_push_instr;
  logic [31:0]   w_target;
  logic          w_target_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          r_mem_fault [DEPTH];
  assign w_target            = redirect_pc;
  assign w_target_misaligned = |redirect_pc[1:0];
`else
  assign w_target            = redirect_pc & 32'hFFFF_FFFC;
  assign w_target_misaligned = 1'b0;
`endif

  assign imem_address = r_pc;
  assign w_pop        = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_space      = (r_count < DEPTH_C) | w_pop;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state logic; redirect overrides everything else.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: w_state_next = S_FETCH;
      S_FAULT: if (w_space) w_state_next = S_HALT;
      default: w_state_next = S_HALT;
    endcase
    if (redirect_valid)
      w_state_next = w_target_misaligned ? S_FAULT : S_FETCH;
  end

  // Output / push-control logic
  always_comb begin
    w_push       = 1'b0;
    w_pc_advance = 1'b0;
    w_push_instr = imem_data;
    case (r_state)
      S_FETCH: begin
        w_push       = imem_valid & w_space;
        w_pc_advance = imem_valid & w_space;
      end
      S_FAULT: begin
        w_push       = w_space;
        w_push_instr = NOP;
      end
      default: ;
    endcase
    // A redirect discards any same-cycle push.
    if (redirect_valid) begin
      w_push       = 1'b0;
      w_pc_advance = 1'b0;
    end

    out_valid = (r_count != '0);
    out_instr = out_valid ? r_mem_instr[r_rd_ptr] : NOP;
    out_pc    = out_valid ? r_mem_pc[r_rd_ptr] : 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    out_fault = out_valid & r_mem_fault[r_rd_ptr];
`else
    out_fault = 1'b0;
`endif
  end

  // PC, occupancy and pointers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_target;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_pc_advance) r_pc     <= r_pc + 32'd4;
      if (w_push)       r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= w_push_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_mem_fault[r_wr_ptr] <= (r_state == S_FAULT);
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scenarios plus randomized traffic for fetch_unit,
// checked against a queue-based reference model of the fetch/FIFO behaviour.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  int nc = 0;
  int np = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  // Instruction memory: a fixed scrambling of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign imem_data = mem_word(imem_address);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_fault_pending;
  bit          m_halted;

  function automatic logic        exp_valid(); return q.size() != 0; endfunction
  function automatic logic [31:0] exp_pc();    return (q.size() != 0) ? q[0].pc : 32'h0; endfunction
  function automatic logic [31:0] exp_instr(); return (q.size() != 0) ? q[0].instr : NOP; endfunction
  function automatic logic        exp_fault(); return (q.size() != 0) ? q[0].fault : 1'b0; endfunction

  // Advance the model with the inputs currently driven, then let the DUT see
  // the same clock edge.
  task automatic tick();
    bit   pop;
    bit   space;
    ent_t e;
    if (!reset) begin
      q.delete();
      m_pc = RESET_PC;
      m_fault_pending = 0;
      m_halted = 0;
    end else if (redirect_valid) begin
      q.delete();
      m_halted = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = redirect_pc;
      m_fault_pending = (redirect_pc % 4) != 0;
`else
      m_pc = redirect_pc - (redirect_pc % 4);
      m_fault_pending = 0;
`endif
    end else begin
      pop   = (q.size() != 0) && out_ready;
      space = (q.size() < DEPTH) || pop;
      if (pop) begin
        $display("pop  pc=%h instr=%h fault=%0d", q[0].pc, q[0].instr, q[0].fault);
        void'(q.pop_front());
      end
      if (m_fault_pending) begin
        if (space) begin
          e.pc = m_pc; e.instr = NOP; e.fault = 1'b1;
          q.push_back(e);
          m_fault_pending = 0;
          m_halted = 1;
        end
      end else if (!m_halted && imem_valid && space) begin
        e.pc = m_pc; e.instr = mem_word(m_pc); e.fault = 1'b0;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    imem_valid = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    do_reset();
    nc++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else np++;
    nc++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", out_pc); else np++;
    nc++; if (out_instr !== NOP) $display("FAIL reset_instr got %h want %h", out_instr, NOP); else np++;
    nc++; if (out_fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", out_fault); else np++;
    nc++; if (imem_address !== RESET_PC) $display("FAIL reset_addr got %h want %h", imem_address, RESET_PC); else np++;
  endtask

  task automatic test_stream();
    reset = 1'b1;
    nc++; if (out_valid !== 1'b0) $display("FAIL stream_first_valid got %0b want 0", out_valid); else np++;
    for (int i = 0; i < 6; i++) begin
      tick();
      nc++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); else np++;
      nc++; if (out_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, 32'(4 * i)); else np++;
      nc++; if (out_instr !== mem_word(32'(4 * i))) $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, mem_word(32'(4 * i))); else np++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    reset = 1'b1; out_ready = 1'b0; imem_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    nc++; if (imem_address !== 32'h8) $display("FAIL bp_addr got %h want 00000008", imem_address); else np++;
    nc++; if (out_pc !== 32'h0) $display("FAIL bp_hold_pc got %h want 0", out_pc); else np++;
    nc++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %0b want 1", out_valid); else np++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nc++; if (out_pc !== 32'(4 * i)) $display("FAIL bp_order[%0d] got %h want %h", i, out_pc, 32'(4 * i)); else np++;
      tick();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    tick();
    tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    nc++; if (out_valid !== 1'b0) $display("FAIL redir_flush got %0b want 0", out_valid); else np++;
    nc++; if (imem_address !== 32'h100) $display("FAIL redir_addr got %h want 00000100", imem_address); else np++;
    tick();
    nc++; if (out_valid !== 1'b1) $display("FAIL redir_valid got %0b want 1", out_valid); else np++;
    nc++; if (out_pc !== 32'h100) $display("FAIL redir_pc got %h want 00000100", out_pc); else np++;
  endtask

  task automatic test_imem_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0; imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nc++; if (imem_address !== 32'h20) $display("FAIL stall_addr[%0d] got %h want 00000020", i, imem_address); else np++;
      nc++; if (out_valid !== 1'b0) $display("FAIL stall_valid[%0d] got %0b want 0", i, out_valid); else np++;
    end
    imem_valid = 1'b1;
    tick();
    nc++; if (out_pc !== 32'h20) $display("FAIL stall_resume got %h want 00000020", out_pc); else np++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    nc++; if (imem_address !== 32'h0) $display("FAIL wrap_addr got %h want 00000000", imem_address); else np++;
    nc++; if (out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", out_pc); else np++;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    nc++; if (out_valid !== 1'b1) $display("FAIL mis_valid got %0b want 1", out_valid); else np++;
    nc++; if (out_fault !== 1'b1) $display("FAIL mis_fault got %0b want 1", out_fault); else np++;
    nc++; if (out_pc !== 32'h102) $display("FAIL mis_pc got %h want 00000102", out_pc); else np++;
    nc++; if (out_instr !== NOP) $display("FAIL mis_instr got %h want %h", out_instr, NOP); else np++;
    for (int i = 0; i < 4; i++) begin
      tick();
      nc++; if (out_valid !== 1'b0) $display("FAIL mis_halt[%0d] got %0b want 0", i, out_valid); else np++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    nc++; if (out_pc !== 32'h200) $display("FAIL mis_resume got %h want 00000200", out_pc); else np++;
    nc++; if (out_fault !== 1'b0) $display("FAIL mis_resume_fault got %0b want 0", out_fault); else np++;
`else
    nc++; if (out_pc !== 32'h100) $display("FAIL mis_pc got %h want 00000100", out_pc); else np++;
    nc++; if (out_fault !== 1'b0) $display("FAIL mis_fault got %0b want 0", out_fault); else np++;
    nc++; if (out_instr !== mem_word(32'h100)) $display("FAIL mis_instr got %h want %h", out_instr, mem_word(32'h100)); else np++;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(99) >= 2);
      imem_valid     = ($urandom_range(99) < 75);
      out_ready      = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 6);
      case ($urandom_range(3))
        0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        1:       redirect_pc = $urandom & 32'h0000_0FFC;
        default: redirect_pc = $urandom;
      endcase
      tick();
      nc++; if (out_valid !== exp_valid()) $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, exp_valid()); else np++;
      nc++; if (out_pc !== exp_pc()) $display("FAIL rnd_pc[%0d] got %h want %h", i, out_pc, exp_pc()); else np++;
      nc++; if (out_instr !== exp_instr()) $display("FAIL rnd_instr[%0d] got %h want %h", i, out_instr, exp_instr()); else np++;
      nc++; if (out_fault !== exp_fault()) $display("FAIL rnd_fault[%0d] got %0b want %0b", i, out_fault, exp_fault()); else np++;
      nc++; if (imem_address !== m_pc) $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_address, m_pc); else np++;
    end
  endtask

  initial begin
    reset = 1'b0; imem_valid = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_imem_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", np, nc);
    $finish;
  end

endmodule
